// File: rtl/mgt_01_divide_unit_pkg.sv
// Shared types and widths for the divide unit.
// Covers the functional-unit status, the RV32M divide opcodes and the divider FSM.
package mgt_01_divide_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        FREE,
        BUSY
    } fu_state_e;

    typedef enum logic [1:0] {
        DIV_,
        DIVU_,
        REM_,
        REMU_
    } div_ops_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIVIDE,
        FIXUP,
        DONE
    } div_fsm_e;

endpackage

// File: rtl/mgt_01_divide_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// It retires one quotient bit per enabled cycle and short-circuits divide-by-zero and signed overflow.
module mgt_01_divide_unit #(
    parameter int unsigned XLEN = mgt_01_divide_unit_pkg::XLEN
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                clk_en_i,
    input  logic [XLEN-1:0]                     dividend_i,
    input  logic [XLEN-1:0]                     divisor_i,
    input  mgt_01_divide_unit_pkg::div_ops_e    operation_i,
    input  logic                                data_valid_i,
    output logic [XLEN-1:0]                     result_o,
    output logic                                data_valid_o,
    output logic                                divide_by_zero_o,
    output mgt_01_divide_unit_pkg::fu_state_e   fu_state_o
);
    import mgt_01_divide_unit_pkg::*;

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    div_fsm_e        r_state, w_state_next;
    div_ops_e        r_op, w_op_next;
    logic [XLEN-1:0] r_dividend, w_dividend_next;
    logic [XLEN-1:0] r_divisor, w_divisor_next;
    logic [XLEN-1:0] r_quo, w_quo_next;
    logic [XLEN-1:0] r_rem, w_rem_next;
    logic [XLEN-1:0] r_result, w_result_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic            r_q_neg, w_q_neg_next;
    logic            r_r_neg, w_r_neg_next;
    logic            r_dbz, w_dbz_next;

    logic            w_signed, w_is_rem, w_dvd_neg, w_dvs_neg;
    logic [XLEN-1:0] w_dvd_abs, w_dvs_abs;
    logic [XLEN:0]   w_shift, w_trial;

    assign w_signed  = (r_op == DIV_) || (r_op == REM_);
    assign w_is_rem  = (r_op == REM_) || (r_op == REMU_);
    assign w_dvd_neg = w_signed & r_dividend[XLEN-1];
    assign w_dvs_neg = w_signed & r_divisor[XLEN-1];
    assign w_dvd_abs = w_dvd_neg ? -r_dividend : r_dividend;
    assign w_dvs_abs = w_dvs_neg ? -r_divisor : r_divisor;

    // The partial remainder is always below the divisor, so only the trial needs the extra bit.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};

    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_dividend_next = r_dividend;
        w_divisor_next  = r_divisor;
        w_quo_next      = r_quo;
        w_rem_next      = r_rem;
        w_result_next   = r_result;
        w_cnt_next      = r_cnt;
        w_q_neg_next    = r_q_neg;
        w_r_neg_next    = r_r_neg;
        w_dbz_next      = r_dbz;
        unique case (r_state)
            IDLE: begin
                if (data_valid_i) begin
                    w_op_next       = operation_i;
                    w_dividend_next = dividend_i;
                    w_divisor_next  = divisor_i;
                    w_state_next    = PREP;
                end
            end
            PREP: begin
                if (r_divisor == '0) begin
                    w_result_next = w_is_rem ? r_dividend : '1;
                    w_dbz_next    = 1'b1;
                    w_state_next  = DONE;
                end else if (w_signed && r_dividend == MinNeg && r_divisor == '1) begin
                    w_result_next = w_is_rem ? '0 : MinNeg;
                    w_dbz_next    = 1'b0;
                    w_state_next  = DONE;
                end else begin
                    w_rem_next     = '0;
                    w_quo_next     = w_dvd_abs;
                    w_divisor_next = w_dvs_abs;
                    w_q_neg_next   = w_dvd_neg ^ w_dvs_neg;
                    w_r_neg_next   = w_dvd_neg;
                    w_cnt_next     = CntW'(XLEN - 1);
                    w_state_next   = DIVIDE;
                end
            end
            DIVIDE: begin
                if (!w_trial[XLEN]) begin
                    w_rem_next = w_trial[XLEN-1:0];
                    w_quo_next = {r_quo[XLEN-2:0], 1'b1};
                end else begin
                    w_rem_next = w_shift[XLEN-1:0];
                    w_quo_next = {r_quo[XLEN-2:0], 1'b0};
                end
                if (r_cnt == '0) begin
                    w_state_next = FIXUP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            FIXUP: begin
                if (w_is_rem) begin
                    w_result_next = r_r_neg ? -r_rem : r_rem;
                end else begin
                    w_result_next = r_q_neg ? -r_quo : r_quo;
                end
                w_dbz_next   = 1'b0;
                w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_op       <= DIV_;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dbz      <= 1'b0;
        end else if (clk_en_i) begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_dividend <= w_dividend_next;
            r_divisor  <= w_divisor_next;
            r_quo      <= w_quo_next;
            r_rem      <= w_rem_next;
            r_result   <= w_result_next;
            r_cnt      <= w_cnt_next;
            r_q_neg    <= w_q_neg_next;
            r_r_neg    <= w_r_neg_next;
            r_dbz      <= w_dbz_next;
        end
    end

    assign result_o         = r_result;
    assign divide_by_zero_o = r_dbz;
    assign data_valid_o     = (r_state == DONE);
    assign fu_state_o       = (r_state == IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_mgt_01_divide_unit.sv
// Self-checking bench for mgt_01_divide_unit.
// It applies table-driven and random vectors through a scoreboard queue, plus hand-written sequences for stall, reset and busy cases.
module tb_mgt_01_divide_unit;
    import mgt_01_divide_unit_pkg::*;

    typedef struct {
        div_ops_e    op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        clk_en_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    div_ops_e    operation_i;
    logic        data_valid_i;
    logic [31:0] result_o;
    logic        data_valid_o;
    logic        divide_by_zero_o;
    fu_state_e   fu_state_o;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   accept_cyc;
    vec_t sb[$];
    vec_t tbl[16];

    mgt_01_divide_unit #(.XLEN(32)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .clk_en_i         (clk_en_i),
        .dividend_i       (dividend_i),
        .divisor_i        (divisor_i),
        .operation_i      (operation_i),
        .data_valid_i     (data_valid_i),
        .result_o         (result_o),
        .data_valid_o     (data_valid_o),
        .divide_by_zero_o (divide_by_zero_o),
        .fu_state_o       (fu_state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic vec_t model(div_ops_e op, logic [31:0] a, logic [31:0] b);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.dbz = 1'b0; v.lat = 35;
        if (b == 32'd0) begin
            v.dbz = 1'b1; v.lat = 2;
            v.res = (op == DIV_ || op == DIVU_) ? 32'hFFFF_FFFF : a;
        end else if ((op == DIV_ || op == REM_) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.lat = 2;
            v.res = (op == DIV_) ? a : 32'd0;
        end else begin
            case (op)
                DIV_:    v.res = $signed(a) / $signed(b);
                REM_:    v.res = $signed(a) % $signed(b);
                DIVU_:   v.res = a / b;
                default: v.res = a % b;
            endcase
        end
        return v;
    endfunction

    task automatic start(input vec_t v, input bit hold, input bit push);
        @(negedge clk);
        operation_i  = v.op;
        dividend_i   = v.a;
        divisor_i    = v.b;
        data_valid_i = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (!hold) data_valid_i = 1'b0;
        if (push) sb.push_back(v);
    endtask

    task automatic wait_result(input int stall_done);
        bit   seen = 1'b0;
        bit   busy_ok = 1'b1;
        bit   held = 1'b1;
        vec_t e;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (fu_state_o != BUSY) busy_ok = 1'b0;
            if (data_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        data_valid_i = 1'b0;
        check("valid_seen", 64'(seen), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                check("result", 64'(result_o), 64'(e.res));
                check("div_by_zero", 64'(divide_by_zero_o), 64'(e.dbz));
                check("latency", 64'(cyc - accept_cyc + 1), 64'(e.lat));
                check("busy_while_running", 64'(busy_ok), 64'd1);
                if (stall_done > 0) begin
                    clk_en_i = 1'b0;
                    repeat (stall_done) begin
                        @(negedge clk);
                        if (!data_valid_o) held = 1'b0;
                    end
                    clk_en_i = 1'b1;
                    check("valid_held_in_done_stall", 64'(held), 64'd1);
                end
                @(negedge clk);
                check("valid_one_pulse", 64'(data_valid_o), 64'd0);
                check("free_after_done", 64'(fu_state_o), 64'(FREE));
            end
        end
    endtask

    initial begin
        vec_t v;
        bit   no_valid;
        rst_n_i      = 1'b1;
        clk_en_i     = 1'b1;
        data_valid_i = 1'b0;
        dividend_i   = '0;
        divisor_i    = '0;
        operation_i  = DIV_;
        #3 rst_n_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_valid", 64'(data_valid_o), 64'd0);
        check("rst_dbz", 64'(divide_by_zero_o), 64'd0);
        check("rst_fu_state", 64'(fu_state_o), 64'(FREE));
        rst_n_i = 1'b1;

        tbl[0]  = '{DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 35};
        tbl[1]  = '{REMU_, 32'd100, 32'd7, 32'd2, 1'b0, 35};
        tbl[2]  = '{DIV_, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 35};
        tbl[3]  = '{REM_, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 35};
        tbl[4]  = '{DIV_, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 35};
        tbl[5]  = '{REM_, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 35};
        tbl[6]  = '{DIV_, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2};
        tbl[7]  = '{REMU_, 32'd5, 32'd0, 32'd5, 1'b1, 2};
        tbl[8]  = '{DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2};
        tbl[9]  = '{REM_, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2};
        tbl[10] = '{DIVU_, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 35};
        tbl[11] = '{DIVU_, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 35};
        tbl[12] = '{REM_, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 1'b1, 2};
        tbl[13] = '{DIVU_, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 2};
        tbl[14] = '{DIV_, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 35};
        tbl[15] = '{REMU_, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 35};

        for (int i = 0; i < 16; i++) begin
            start(tbl[i], 1'b0, 1'b1);
            wait_result(0);
        end

        for (int i = 0; i < 8; i++) begin
            v = model(div_ops_e'($urandom_range(0, 3)), $urandom,
                      $urandom >> $urandom_range(0, 31));
            start(v, 1'b0, 1'b1);
            wait_result(0);
        end

        // Five stalled cycles in the middle of DIVIDE push the result out by five.
        v = '{DIVU_, 32'd1000, 32'd3, 32'd333, 1'b0, 40};
        start(v, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        clk_en_i = 1'b0;
        repeat (5) @(negedge clk);
        clk_en_i = 1'b1;
        wait_result(0);

        // A start request held high with changing operands must not disturb the running op.
        v = '{DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 35};
        start(v, 1'b1, 1'b1);
        operation_i = DIV_;
        dividend_i  = 32'd9;
        divisor_i   = 32'd3;
        wait_result(0);

        v = '{DIV_, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2};
        start(v, 1'b0, 1'b1);
        wait_result(3);

        v = '{REMU_, 32'd12345, 32'd10, 32'd5, 1'b0, 35};
        start(v, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        rst_n_i = 1'b0;
        #1;
        check("abort_result", 64'(result_o), 64'd0);
        check("abort_valid", 64'(data_valid_o), 64'd0);
        check("abort_dbz", 64'(divide_by_zero_o), 64'd0);
        check("abort_fu_state", 64'(fu_state_o), 64'(FREE));
        no_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        repeat (45) begin
            @(negedge clk);
            if (data_valid_o) no_valid = 1'b0;
        end
        check("abort_no_spurious_valid", 64'(no_valid), 64'd1);

        v = '{DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 35};
        start(v, 1'b0, 1'b1);
        wait_result(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mgt_01_divide_unit.md
# mgt_01_divide_unit

Iterative integer divide unit for the RV32M `DIV`, `DIVU`, `REM` and `REMU` operations. It sits in the execute stage beside the multiply unit and uses the same conventions:

- shared `fu_state_e` busy/free status;
- clock-enable stall input;
- operand/result widths set by `XLEN`.

It uses radix-2 restoring division, one quotient bit per cycle, with no pipelining, to save area. Divide-by-zero and signed overflow are short-circuited as the ISA requires.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk_i` input 1: clock, rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low. One clock, asynchronous active-low reset.
- `clk_en_i` input 1: when low, every register holds (stall).
- `dividend_i` input XLEN: dividend (rs1).
- `divisor_i` input XLEN: divisor (rs2).
- `operation_i` input `div_ops_e`: `DIV_`, `DIVU_`, `REM_`, `REMU_`.
- `data_valid_i` input 1: start request; sampled only in IDLE.
- `result_o` output XLEN: quotient or remainder. Holds its value until the next completion.
- `data_valid_o` output 1: one-cycle pulse when `result_o` is new.
- `divide_by_zero_o` output 1: qualifies `data_valid_o`; divisor was 0.
- `fu_state_o` output `fu_state_e`: FREE in IDLE, BUSY otherwise.

## Operation
- **FSM states:** IDLE, PREP, DIVIDE, FIXUP, DONE.
- **IDLE:**
  - If `data_valid_i & clk_en_i`, latch the operands and `operation_i`, then go to PREP.
  - `data_valid_i` is ignored in every other state.
- **PREP:**
  - Signed ops (`DIV_`, `REM_`): take absolute values; record `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend).
  - Unsigned ops: `q_neg` = `r_neg` = 0.
  - Divisor == 0: go to DONE with the result loaded directly.
    - `DIV_`/`DIVU_` give all-ones.
    - `REM_`/`REMU_` give the dividend.
    - Set `divide_by_zero_o` = 1.
  - Signed op with dividend 0x8000_0000 and divisor all-ones (overflow): go to DONE.
    - `DIV_` gives 0x8000_0000.
    - `REM_` gives 0.
  - Otherwise: clear the XLEN+1-bit remainder, load the quotient register with |dividend|, set the iteration counter to XLEN-1, and go to DIVIDE.
- **DIVIDE:** one iteration per enabled cycle.
  - Compute trial = {rem[XLEN-1:0], quo[XLEN-1]} − {0, |divisor|}.
  - If trial ≥ 0 (MSB clear): rem = trial, and shift a 1 into quo.
  - Else: rem = the shifted value, and shift a 0 into quo.
  - At counter 0, go to FIXUP; otherwise decrement the counter.
- **FIXUP:**
  - Quotient ops: result = `q_neg` ? −quo : quo.
  - Remainder ops: result = `r_neg` ? −rem : rem.
  - Go to DONE.
- **DONE:** `data_valid_o` = 1 for this one cycle; go to IDLE on the next enabled edge.
- **Arithmetic:** XLEN-bit wrap in two's complement; no exceptions are raised.

## Timing
- **Reset (asynchronous):**
  - State goes to IDLE.
  - `result_o` = 0, `data_valid_o` = 0, `divide_by_zero_o` = 0, `fu_state_o` = FREE.
  - Internal counter and registers go to 0.
  - Reset during any state aborts the operation; no `data_valid_o` is produced.
- **Normal latency:** start is accepted at edge E0. Then:
  - PREP at E1;
  - DIVIDE through E1+XLEN;
  - FIXUP at E2+XLEN.
  - `data_valid_o` is high in the cycle after edge E0+XLEN+2, i.e. after edge E34 for XLEN = 32.
- **Short-circuit latency:** `data_valid_o` is high in the cycle after edge E1.
- **Stall:** each cycle with `clk_en_i` = 0 adds exactly one cycle of latency. While stalled in DONE, `data_valid_o` stays high until the DONE→IDLE edge.
- **Back-to-back starts:** the earliest next start is accepted at the edge after DONE, i.e. in IDLE.
- **`fu_state_o`:** BUSY from the E0 edge until DONE exits.
- **Output timing:** `result_o` and `divide_by_zero_o` are registered and change only when DONE is entered.

## Structure
- `Instruction_pkg.svh` gains the `div_ops_e` enum: `DIV_`, `DIVU_`, `REM_`, `REMU_`.
- `Modules_pkg.svh` supplies `XLEN` and `fu_state_e`, which already exist.
- `Modules_pkg.svh` gains the `div_fsm_e` enum: IDLE, PREP, DIVIDE, FIXUP, DONE.
- A single module. The trial-subtract step is inline combinational logic; no sub-module is needed.

## Test plan
- **Unsigned:** `DIVU_` 100/7 gives 14, and `REMU_` 100/7 gives 2.
  - `data_valid_o` pulses exactly 35 cycles after the accepting edge; `fu_state_o` is BUSY throughout.
- **Signed:** `DIV_` −7/2 gives 0xFFFF_FFFD (−3), and `REM_` −7/2 gives 0xFFFF_FFFF (−1).
  - `DIV_` 7/−2 gives −3, and `REM_` 7/−2 gives 1.
- **Divide by zero:** `DIV_` 5/0 gives 0xFFFF_FFFF, and `REMU_` 5/0 gives 5.
  - `divide_by_zero_o` = 1 and valid arrives 2 cycles after the start.
- **Overflow:** `DIV_` 0x8000_0000 / 0xFFFF_FFFF gives 0x8000_0000, and `REM_` gives 0; short latency.
- **Extremes:** `DIVU_` 0xFFFF_FFFF/1 gives 0xFFFF_FFFF, and `DIVU_` 3/0xFFFF_FFFF gives 0.
- **Control:**
  - Drop `clk_en_i` for 5 cycles mid-DIVIDE: valid arrives 5 cycles later and the result is unchanged.
  - Assert `rst_n_i` low at iteration 10: outputs go to 0 and FREE immediately, with no spurious valid.
  - Hold `data_valid_i` high while BUSY: it is ignored.
